display_scan_mux: RTL and testbench
===================================

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of selectable display channels, legal range 2..16.
REQ-002 SHALL have parameter WIDTH, default 16: bits per channel word; must be a multiple of 4, else elaboration error.
REQ-003 SHALL have parameter AUTO_DIV, default 50_000_000: clk cycles per channel in auto-scan mode, >=2.
REQ-004 SHALL have parameter REFRESH_DIV, default 100_000: clk cycles per 7-segment digit slot, >=1.
REQ-005 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port ch_data, input, CHANNELS*WIDTH: packed channel words, channel k at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port step, input, 1: level from a debounced button; each 0->1 transition requests the next channel.
REQ-009 SHALL have port auto_mode, input, 1: 0 = manual stepping, 1 = auto-scan.
REQ-010 SHALL have port freeze, input, 1: 1 holds the displayed word and channel.
REQ-011 SHALL have port disp_data, output, WIDTH: registered word of the selected channel.
REQ-012 SHALL have port disp_ch, output, clog2(CHANNELS): currently selected channel index.
REQ-013 SHALL have port an, output, WIDTH/4: active-low one-hot digit enable.
REQ-014 SHALL have port hex, output, 4: nibble for the enabled digit.

Function
REQ-015 SHALL register step once and detect edge as step & ~step_q; level-high with no transition causes no action.
REQ-016 SHALL, on a step edge with freeze=0, advance disp_ch by 1, wrapping CHANNELS-1 -> 0.
REQ-017 SHALL, in auto_mode=1 with freeze=0, count 0..AUTO_DIV-1 and advance disp_ch (with wrap) on the terminal count, then restart at 0.
REQ-018 SHALL, when a step edge and the auto terminal count coincide, advance disp_ch by exactly 1 and restart the auto counter at 0.
REQ-019 SHALL restart the auto counter at 0 on any step edge in auto mode and hold it at 0 while auto_mode=0.
REQ-020 SHALL, while freeze=1, hold disp_ch, disp_data and the auto counter, and ignore step edges (step_q still tracks step).
REQ-021 SHALL, while freeze=0, load disp_data with ch_data word of disp_ch every cycle; a channel change appears in disp_data one cycle after disp_ch updates.
REQ-022 SHALL refresh digits continuously, including under freeze: slot counter 0..REFRESH_DIV-1; on terminal count, digit index increments, wrapping WIDTH/4-1 -> 0.
REQ-023 SHALL drive an low only at bit digit index, and hex = disp_data[4*idx +: 4], both registered in the same cycle.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, set disp_ch=0, disp_data=0, auto counter=0, step_q=0, slot counter=0, digit index=0, an = all ones except bit 0 low, hex=0.
REQ-025 SHALL let reset override step, auto_mode and freeze in the same cycle, including mid-auto-count and mid-freeze.

Structure
REQ-026 SHALL put the mode encoding (MANUAL=0, AUTO=1) and default AUTO_DIV/REFRESH_DIV constants in shared package display_pkg.
REQ-027 SHALL implement digit refresh (REQ-022, REQ-023) as sub-module seg_scan, parametrised by WIDTH and REFRESH_DIV.

Verification (CHANNELS=4, WIDTH=16, AUTO_DIV=8, REFRESH_DIV=2; ch_data words 0x1111, 0x2222, 0x3333, 0x4444 for ch0..3)
REQ-028 SHALL cover: reset, then manual, five step pulses -> disp_ch 1,2,3,0,1; disp_data 0x2222 one cycle after disp_ch=1.
REQ-029 SHALL cover: step held high 20 cycles -> exactly one advance.
REQ-030 SHALL cover: auto_mode=1 from disp_ch=0 -> disp_ch=1 after 8 cycles, 0 after 32 cycles; a step edge on the terminal cycle -> single advance, counter restarts.
REQ-031 SHALL cover: freeze=1 at disp_ch=2, ch_data word 2 changed to 0xABCD, steps and 40 cycles of auto -> disp_ch=2, disp_data=0x3333; freeze=0 -> 0xABCD next cycle.
REQ-032 SHALL cover: disp_data=0x1234 -> an/hex sequence 1110/4, 1101/3, 1011/2, 0111/1, each held 2 cycles, repeating.
REQ-033 SHALL cover: reset asserted mid-auto-count with freeze=1 -> all outputs at REQ-024 values at the next edge.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and helpers for the display channel scanner and its digit refresher.
package display_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_e;

  localparam int unsigned DEFAULT_AUTO_DIV    = 50_000_000;
  localparam int unsigned DEFAULT_REFRESH_DIV = 100_000;

  // Increment an index that wraps from last back to zero.
  function automatic int unsigned wrap_inc(input int unsigned cur, input int unsigned last);
    return (cur == last) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Time-multiplexed 7-segment digit refresher: walks one active-low digit enable
// across the word and presents the matching nibble, both registered together.
module seg_scan
  import display_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data,
  output logic [WIDTH/4-1:0] an,
  output logic [3:0]         hex
);

  localparam int DIGITS = WIDTH / 4;
  localparam int SW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SW-1:0] slot;
  logic [IW-1:0] idx;
  logic          slot_end;

  assign slot_end = (slot == SW'(REFRESH_DIV - 1));

  // Refresh keeps running regardless of the channel freeze; only reset stops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
      idx  <= '0;
      an   <= ~DIGITS'(1);
      hex  <= 4'h0;
    end else begin
      slot <= slot_end ? '0 : slot + 1'b1;
      if (slot_end) begin
        idx <= IW'(wrap_inc(32'(idx), DIGITS - 1));
      end
      an  <= ~(DIGITS'(1) << idx);
      hex <= data[32'(idx)*4 +: 4];
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Selects one of several channel words for display, stepped by button or auto-scan,
// with a freeze that holds the shown word while digit refresh continues.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int AUTO_DIV    = DEFAULT_AUTO_DIV,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS*WIDTH-1:0]   ch_data,
  input  logic                        step,
  input  logic                        auto_mode,
  input  logic                        freeze,
  output logic [WIDTH-1:0]            disp_data,
  output logic [$clog2(CHANNELS)-1:0] disp_ch,
  output logic [WIDTH/4-1:0]          an,
  output logic [3:0]                  hex
);

  localparam int CW = $clog2(CHANNELS);
  localparam int AW = $clog2(AUTO_DIV);

  if (WIDTH % 4 != 0) begin : g_bad_width
    $error("display_scan_mux: WIDTH must be a multiple of 4");
  end
  if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
    $error("display_scan_mux: CHANNELS must be in 2..16");
  end
  if (AUTO_DIV < 2) begin : g_bad_auto_div
    $error("display_scan_mux: AUTO_DIV must be at least 2");
  end
  if (REFRESH_DIV < 1) begin : g_bad_refresh_div
    $error("display_scan_mux: REFRESH_DIV must be at least 1");
  end

  mode_e            mode;
  logic             step_q;
  logic             step_edge;
  logic             auto_end;
  logic             advance;
  logic [AW-1:0]    auto_cnt;
  logic [WIDTH-1:0] sel_word;

  assign mode = mode_e'(auto_mode);

  always_comb begin
    step_edge = step & ~step_q;
    auto_end  = (mode == AUTO) && (auto_cnt == AW'(AUTO_DIV - 1));
    advance   = step_edge | auto_end;
    sel_word  = ch_data[32'(disp_ch)*WIDTH +: WIDTH];
  end

  // A step edge and an auto terminal count landing together still move one channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q    <= 1'b0;
      disp_ch   <= '0;
      disp_data <= '0;
      auto_cnt  <= '0;
    end else begin
      step_q <= step;
      if (!freeze) begin
        disp_data <= sel_word;
        if (advance) begin
          disp_ch <= CW'(wrap_inc(32'(disp_ch), CHANNELS - 1));
        end
        if (mode == MANUAL || advance) begin
          auto_cnt <= '0;
        end else begin
          auto_cnt <= auto_cnt + 1'b1;
        end
      end
    end
  end

  seg_scan #(
    .WIDTH       (WIDTH),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_seg_scan (
    .clk   (clk),
    .reset (reset),
    .data  (disp_data),
    .an    (an),
    .hex   (hex)
  );

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed scenarios plus random traffic, checked
// cycle by cycle against a time-based reference model through an expected queue.
module tb_display_scan_mux;

  localparam int C  = 4;
  localparam int W  = 16;
  localparam int AD = 8;
  localparam int RD = 2;
  localparam int D  = W / 4;
  localparam int CW = $clog2(C);
  localparam int EW = CW + W + D + 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           step;
  logic           auto_mode;
  logic           freeze;
  logic [C*W-1:0] ch_data;
  logic [W-1:0]   disp_data;
  logic [CW-1:0]  disp_ch;
  logic [D-1:0]   an;
  logic [3:0]     hex;

  always #5 clk = ~clk;

  display_scan_mux #(
    .CHANNELS    (C),
    .WIDTH       (W),
    .AUTO_DIV    (AD),
    .REFRESH_DIV (RD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_data   (ch_data),
    .step      (step),
    .auto_mode (auto_mode),
    .freeze    (freeze),
    .disp_data (disp_data),
    .disp_ch   (disp_ch),
    .an        (an),
    .hex       (hex)
  );

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: shown channel/word, cycles since the auto count restarted,
  // previous step level and clock edges elapsed since reset.
  int         m_ch;
  int         m_acnt;
  int         m_t;
  bit         m_stepq;
  logic [W-1:0] m_data;

  task automatic tick();
    logic [EW-1:0] e;
    logic [W-1:0]  old_data;
    int            idx;
    bit            stp_edge;
    bit            term;
    if (reset) begin
      m_ch = 0; m_acnt = 0; m_t = 0; m_stepq = 0; m_data = '0;
      e = {CW'(0), W'(0), ~D'(1), 4'h0};
    end else begin
      idx      = (m_t / RD) % D;
      old_data = m_data;
      stp_edge = step && !m_stepq;
      m_stepq  = step;
      if (!freeze) begin
        m_data = W'(ch_data >> (m_ch * W));
        term   = auto_mode && (m_acnt == AD - 1);
        if (stp_edge || term) begin
          m_ch   = (m_ch + 1) % C;
          m_acnt = 0;
        end else if (auto_mode) begin
          m_acnt = m_acnt + 1;
        end
        if (!auto_mode) m_acnt = 0;
      end
      m_t = m_t + 1;
      e = {CW'(m_ch), m_data, ~(D'(1) << idx), 4'((old_data >> (4 * idx)) & 16'hF)};
    end
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_step();
    step = 1'b1; tick();
    step = 1'b0; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick();
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  initial begin : monitor
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("disp_ch",   32'(disp_ch),   32'(e[EW-1 -: CW]));
        check("disp_data", 32'(disp_data), 32'(e[D+4+W-1 -: W]));
        check("an",        32'(an),        32'(e[D+4-1 -: D]));
        check("hex",       32'(hex),       32'(e[3:0]));
      end
    end
  end

  initial begin : stimulus
    int k;
    step      = 1'b0;
    auto_mode = 1'b0;
    freeze    = 1'b0;
    reset     = 1'b1;
    ch_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    tick();
    do_reset();
    run(2);

    // Manual stepping, wrapping through all channels.
    for (int i = 0; i < 5; i++) begin
      pulse_step();
      run(1);
    end

    // Held step level gives one advance only.
    step = 1'b1; run(20);
    step = 1'b0; run(2);

    // Auto scan from channel 0, then a step edge landing on the terminal count.
    do_reset();
    auto_mode = 1'b1;
    run(32);
    for (int i = 0; i < AD && m_acnt != AD - 1; i++) tick();
    step = 1'b1; tick();
    step = 1'b0; run(AD + 2);

    // Freeze at channel 2 while its word changes and steps/auto try to move it.
    auto_mode = 1'b0;
    do_reset();
    pulse_step();
    pulse_step();
    run(2);
    freeze = 1'b1;
    ch_data[2*W +: W] = 16'hABCD;
    for (int i = 0; i < 3; i++) pulse_step();
    auto_mode = 1'b1;
    run(40);
    auto_mode = 1'b0;
    freeze = 1'b0;
    run(3);

    // Digit scan of a known word.
    ch_data[m_ch*W +: W] = 16'h1234;
    run(20);

    // Reset mid auto count while frozen.
    auto_mode = 1'b1;
    run(5);
    freeze = 1'b1;
    run(3);
    do_reset();
    freeze = 1'b0;
    auto_mode = 1'b0;
    run(3);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) auto_mode = ~auto_mode;
      if ($urandom_range(0, 29) == 0) freeze = ~freeze;
      if ($urandom_range(0, 19) == 0) begin
        k = $urandom_range(0, C - 1);
        ch_data[k*W +: W] = W'($urandom);
      end
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    step  = 1'b0;
    run(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
